// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer slice.
// - state_t     : timer FSM states
// - BCD_W       : width of one BCD digit
// - IDX_*       : digit positions within the 20-bit digits bus (tenths is digit 0)
// - *_WRAP      : values the tenths and units digits reload with on a borrow
// - clamp_digit : limits a loaded digit to a legal maximum
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 5;

  localparam int IDX_TENTHS    = 0;
  localparam int IDX_SEC_UNITS = 1;
  localparam int IDX_SEC_TENS  = 2;
  localparam int IDX_MIN_UNITS = 3;
  localparam int IDX_MIN_TENS  = 4;

  localparam logic [BCD_W-1:0] TENTHS_WRAP = 4'd9;
  localparam logic [BCD_W-1:0] UNITS_WRAP  = 4'd9;

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// Inputs to the timer : enable, tick_100ms, load, load_value, start, pause
// Outputs of the timer: digits {min_tens, min_units, sec_tens, sec_units, tenths},
//                       running, done, expired
// modport slave  : the timer itself
// modport master : whoever drives the controls and watches the display
interface countdown_timer_if;

  logic        enable;
  logic        tick_100ms;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [19:0] digits;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output enable, tick_100ms, load, load_value, start, pause,
    input  digits, running, done, expired
  );

  modport slave (
    input  enable, tick_100ms, load, load_value, start, pause,
    output digits, running, done, expired
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit.
// Ports:
//   clk, rst     : clock, synchronous active-low reset (digit clears to 0)
//   load         : capture load_val (wins over dec)
//   load_val     : already-legal BCD value to load
//   dec          : decrement this digit by one
//   wrap         : value taken when decrementing from 0
//   digit        : registered digit value
//   borrow_out   : dec while digit==0, i.e. the next digit up must decrement
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec,
  input  logic [BCD_W-1:0] wrap,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  assign borrow_out = dec && (digit == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == '0) ? wrap : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.t BCD countdown timer driven by a 100 ms tick.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : countdown_timer_if.slave (controls in, digits/running/done/expired out)
// The FSM, load clamping, zero/last detection and the expiry pulse live here;
// the five digits are bcd_down_digit instances chained by borrow.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5,
  parameter int SEC_TENS_MAX = 5
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);

  localparam logic [BCD_W-1:0] MT_MAX = BCD_W'(MIN_TENS_MAX);
  localparam logic [BCD_W-1:0] ST_MAX = BCD_W'(SEC_TENS_MAX);

  state_t state;
  logic   running_q;
  logic   done_q;
  logic   expired_q;

  logic [BCD_W-1:0] dig [NUM_DIGITS];
  logic [BCD_W-1:0] ld_val [NUM_DIGITS];
  logic [19:0]      digits_w;

  logic ld_acc;
  logic tick_acc;
  logic borrow_t;
  logic borrow_su;
  logic borrow_st;
  logic borrow_mu;
  logic borrow_unused;
  logic is_zero;
  logic is_last;

  assign digits_w = {dig[IDX_MIN_TENS], dig[IDX_MIN_UNITS], dig[IDX_SEC_TENS],
                     dig[IDX_SEC_UNITS], dig[IDX_TENTHS]};

  assign is_zero = (digits_w == 20'h00000);
  assign is_last = (digits_w == 20'h00001);

  // A tick only counts in RUN and only when no higher-priority control
  // (load or pause) is present in the same cycle.
  assign ld_acc   = bus.enable && bus.load;
  assign tick_acc = bus.enable && !bus.load && !bus.pause && bus.tick_100ms &&
                    (state == RUN);

  assign ld_val[IDX_MIN_TENS]  = clamp_digit(bus.load_value[15:12], MT_MAX);
  assign ld_val[IDX_MIN_UNITS] = clamp_digit(bus.load_value[11:8], UNITS_WRAP);
  assign ld_val[IDX_SEC_TENS]  = clamp_digit(bus.load_value[7:4], ST_MAX);
  assign ld_val[IDX_SEC_UNITS] = clamp_digit(bus.load_value[3:0], UNITS_WRAP);
  assign ld_val[IDX_TENTHS]    = '0;

  bcd_down_digit u_tenths (
    .clk(clk), .rst(rst), .load(ld_acc), .load_val(ld_val[IDX_TENTHS]),
    .dec(tick_acc), .wrap(TENTHS_WRAP),
    .digit(dig[IDX_TENTHS]), .borrow_out(borrow_t)
  );

  bcd_down_digit u_sec_units (
    .clk(clk), .rst(rst), .load(ld_acc), .load_val(ld_val[IDX_SEC_UNITS]),
    .dec(borrow_t), .wrap(UNITS_WRAP),
    .digit(dig[IDX_SEC_UNITS]), .borrow_out(borrow_su)
  );

  bcd_down_digit u_sec_tens (
    .clk(clk), .rst(rst), .load(ld_acc), .load_val(ld_val[IDX_SEC_TENS]),
    .dec(borrow_su), .wrap(ST_MAX),
    .digit(dig[IDX_SEC_TENS]), .borrow_out(borrow_st)
  );

  bcd_down_digit u_min_units (
    .clk(clk), .rst(rst), .load(ld_acc), .load_val(ld_val[IDX_MIN_UNITS]),
    .dec(borrow_st), .wrap(UNITS_WRAP),
    .digit(dig[IDX_MIN_UNITS]), .borrow_out(borrow_mu)
  );

  // Minutes-tens never borrows: RUN is never entered at zero and the count
  // leaves RUN on reaching zero, so its wrap value is never used.
  bcd_down_digit u_min_tens (
    .clk(clk), .rst(rst), .load(ld_acc), .load_val(ld_val[IDX_MIN_TENS]),
    .dec(borrow_mu), .wrap(4'd0),
    .digit(dig[IDX_MIN_TENS]), .borrow_out(borrow_unused)
  );

  // Priority: load > pause > start > tick. A pause in any state therefore
  // masks a simultaneous start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (!bus.enable) begin
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.load) begin
        state     <= IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            if (!bus.pause && bus.start && !is_zero) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else if (bus.tick_100ms && is_last) begin
              state     <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              expired_q <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.digits  = digits_w;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised + directed bench for countdown_timer. The reference model keeps
// the remaining time as an integer number of tenths and converts it to BCD.
module tb_countdown_timer;

  logic clk;
  logic rst;

  countdown_timer_if bus ();

  countdown_timer #(.MIN_TENS_MAX(5), .SEC_TENS_MAX(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] digits;
    logic        running;
    logic        done;
    logic        expired;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model state: remaining tenths and a mode (0 idle, 1 run, 2 paused, 3 done)
  int m_t    = 0;
  int m_mode = 0;
  bit m_exp  = 1'b0;

  function automatic logic [19:0] to_bcd(input int t);
    int m, s, f;
    f = t % 10;
    s = (t / 10) % 60;
    m = t / 600;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(f)};
  endfunction

  function automatic int lim(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int load_tenths(input logic [15:0] v);
    int mt, mu, st, su;
    mt = lim(int'(v[15:12]), 5);
    mu = lim(int'(v[11:8]), 9);
    st = lim(int'(v[7:4]), 5);
    su = lim(int'(v[3:0]), 9);
    return ((mt * 10 + mu) * 60 + st * 10 + su) * 10;
  endfunction

  task automatic cyc(input bit r, input bit e, input bit l, input logic [15:0] v,
                     input bit s, input bit p, input bit t);
    exp_t x;
    rst            = r;
    bus.enable     = e;
    bus.load       = l;
    bus.load_value = v;
    bus.start      = s;
    bus.pause      = p;
    bus.tick_100ms = t;
    @(posedge clk);
    if (!r) begin
      m_t = 0; m_mode = 0; m_exp = 1'b0;
    end else if (!e) begin
      m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (l) begin
        m_t = load_tenths(v);
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (p) m_mode = 2;
        else if (t) begin
          m_t = m_t - 1;
          if (m_t == 0) begin
            m_mode = 3;
            m_exp = 1'b1;
          end
        end
      end else if ((m_mode == 0 || m_mode == 2) && !p && s && m_t != 0) begin
        m_mode = 1;
      end
    end
    x.digits  = to_bcd(m_t);
    x.running = (m_mode == 1);
    x.done    = (m_mode == 3);
    x.expired = m_exp;
    q.push_back(x);
    #1;
  endtask

  task automatic idle();    cyc(1, 1, 0, 16'h0, 0, 0, 0); endtask
  task automatic tk();      cyc(1, 1, 0, 16'h0, 0, 0, 1); endtask
  task automatic go();      cyc(1, 1, 0, 16'h0, 1, 0, 0); endtask
  task automatic ld(input logic [15:0] v); cyc(1, 1, 1, v, 0, 0, 0); endtask
  task automatic reset_pulse(); cyc(0, 1, 0, 16'h0, 0, 0, 0); endtask

  // Monitor: outputs are valid every cycle; compare one entry per falling edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a.digits  = bus.digits;
        a.running = bus.running;
        a.done    = bus.done;
        a.expired = bus.expired;
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got digits=%05h run=%0b done=%0b exp=%0b, want digits=%05h run=%0b done=%0b exp=%0b",
                   $time, a.digits, a.running, a.done, a.expired,
                   e.digits, e.running, e.done, e.expired);
        end
      end
    end
  end

  initial begin
    bit r, e, l, s, p, t;
    logic [15:0] v;

    // Reset, then a zero load cannot be started and ticks do nothing
    reset_pulse(); reset_pulse();
    ld(16'h0000); go();
    repeat (3) tk();

    // 00:01.0 down to expiry, then DONE is sticky
    ld(16'h0001); go();
    repeat (10) tk();
    idle(); tk(); go(); idle();

    // Full borrow chain
    ld(16'h1000); go(); tk(); idle();

    // Pause wins over a same-cycle tick; ticks while paused are dropped
    ld(16'h0005); go();
    repeat (3) tk();
    cyc(1, 1, 0, 16'h0, 0, 1, 1);
    repeat (5) tk();
    go(); tk(); idle();

    // Clamping, load beats start, reset mid-run
    ld(16'hF9F9);
    cyc(1, 1, 1, 16'hF9F9, 1, 0, 0);
    idle(); go(); tk(); tk();
    reset_pulse(); idle();

    // Ticks while disabled are lost
    ld(16'h0002); go();
    for (int i = 0; i < 20; i++) cyc(1, (i < 4 || i > 8), 0, 16'h0, 0, 0, 1);
    idle();

    // Randomised traffic, biased toward short loads so expiries occur
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 599) != 0);
      e = ($urandom_range(0, 19) != 0);
      l = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 14) == 0);
      p = ($urandom_range(0, 59) == 0);
      t = ($urandom_range(0, 2) != 0);
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 0) v = {12'h000, v[3:0]};
      cyc(r, e, l, v, s, p, t);
    end
    idle();

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
